// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and default widths for the counter checker
//
// Purpose: checker FSM state encoding and default parameter values used by
//          counter_checker and its saturating counters.
// Ports:   none (package).

package counter_pkg;

    localparam int DEF_W        = 4;  // observed counter width
    localparam int DEF_CW       = 8;  // error / wrap counter width
    localparam int DEF_LOCK_RUN = 2;  // matches needed to leave RESYNC

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_RESYNC   = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts Inc pulses, holds at all-ones instead of rolling over.
// Ports:
//   Clk    input   1   system clock, rising edge
//   Rst_n  input   1   asynchronous active-low reset
//   Clr    input   1   synchronous clear (wins over Inc)
//   Inc    input   1   increment request
//   Count  output  CW  current count

module sat_counter
    import counter_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Clr,
    input  logic          Inc,
    output logic [CW-1:0] Count
);

    logic [CW-1:0] count_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count_q <= '0;
        end else if (Clr) begin
            count_q <= '0;
        end else if (Inc && (count_q != {CW{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign Count = count_q;

endmodule

// File: rtl/counter_checker.sv
// rtl/counter_checker.sv - sequence monitor for a W-bit up-counter output stream
//
// Purpose: checks that each valid sample equals the previous sample +1 (mod 2^W),
//          re-synchronises on Load, counts mismatches and checked wrap-arounds.
// Ports:
//   Clk        input   1   system clock, rising edge
//   Rst_n      input   1   asynchronous active-low reset
//   DataIn     input   W   observed counter value
//   Valid      input   1   DataIn is a new sample this cycle
//   Load       input   1   sample is a new reference, not checked
//   Clear      input   1   synchronous clear of counters and lock state
//   Locked     output  1   high while in LOCKED
//   ErrPulse   output  1   one-cycle pulse per detected mismatch
//   ErrCount   output  CW  saturating mismatch count
//   WrapCount  output  CW  saturating count of checked max->0 transitions
//   Expected   output  W   next expected value

module counter_checker
    import counter_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int CW       = DEF_CW,
    parameter int LOCK_RUN = DEF_LOCK_RUN
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic [W-1:0]  DataIn,
    input  logic          Valid,
    input  logic          Load,
    input  logic          Clear,
    output logic          Locked,
    output logic          ErrPulse,
    output logic [CW-1:0] ErrCount,
    output logic [CW-1:0] WrapCount,
    output logic [W-1:0]  Expected
);

    localparam int RW = $clog2(LOCK_RUN + 1);

    state_t        state_q, state_d;
    logic [W-1:0]  expected_q, expected_d;
    logic [RW-1:0] run_q, run_d;
    logic          err_pulse_q, err_pulse_d;
    logic          err_inc, wrap_inc;

    logic [W-1:0]  data_next;
    logic          match;
    logic          at_max;

    assign data_next = DataIn + 1'b1;
    assign match     = (DataIn == expected_q);
    assign at_max    = (DataIn == {W{1'b1}});

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_UNLOCKED;
            expected_q  <= '0;
            run_q       <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            run_q       <= run_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        run_d       = run_q;
        err_pulse_d = 1'b0;
        err_inc     = 1'b0;
        wrap_inc    = 1'b0;

        if (Clear) begin
            state_d    = ST_UNLOCKED;
            expected_d = '0;
            run_d      = '0;
        end else if (Valid) begin
            // Every accepted sample becomes the reference for the next one,
            // whether it matched, mismatched or was a load.
            expected_d = data_next;

            if ((state_q == ST_UNLOCKED) || Load) begin
                state_d = ST_LOCKED;
                run_d   = '0;
            end else if (match) begin
                wrap_inc = at_max;
                if (state_q == ST_RESYNC) begin
                    // This match completes the run when run_q already holds
                    // LOCK_RUN-1 earlier matches.
                    if (run_q == RW'(LOCK_RUN - 1)) begin
                        state_d = ST_LOCKED;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
            end else begin
                err_pulse_d = 1'b1;
                err_inc     = 1'b1;
                state_d     = ST_RESYNC;
                run_d       = '0;
            end
        end
    end

    sat_counter #(.CW(CW)) u_err_count (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Clr   (Clear),
        .Inc   (err_inc),
        .Count (ErrCount)
    );

    sat_counter #(.CW(CW)) u_wrap_count (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Clr   (Clear),
        .Inc   (wrap_inc),
        .Count (WrapCount)
    );

    assign Locked   = (state_q == ST_LOCKED);
    assign ErrPulse = err_pulse_q;
    assign Expected = expected_q;

endmodule

// File: tb/tb_counter_checker.sv
// tb/tb_counter_checker.sv - directed self-checking bench for counter_checker

module tb_counter_checker;

    logic       Clk;
    logic       Rst_n;
    logic [3:0] DataIn;
    logic       Valid;
    logic       Load;
    logic       Clear;

    logic       locked_a, errpulse_a;
    logic [7:0] errcount_a, wrapcount_a;
    logic [3:0] expected_a;

    logic       locked_b, errpulse_b;
    logic [1:0] errcount_b, wrapcount_b;
    logic [3:0] expected_b;

    int n_checks = 0;
    int n_fail   = 0;

    counter_checker #(.W(4), .CW(8), .LOCK_RUN(2)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .DataIn    (DataIn),
        .Valid     (Valid),
        .Load      (Load),
        .Clear     (Clear),
        .Locked    (locked_a),
        .ErrPulse  (errpulse_a),
        .ErrCount  (errcount_a),
        .WrapCount (wrapcount_a),
        .Expected  (expected_a)
    );

    counter_checker #(.W(4), .CW(2), .LOCK_RUN(2)) dut_cw2 (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .DataIn    (DataIn),
        .Valid     (Valid),
        .Load      (Load),
        .Clear     (Clear),
        .Locked    (locked_b),
        .ErrPulse  (errpulse_b),
        .ErrCount  (errcount_b),
        .WrapCount (wrapcount_b),
        .Expected  (expected_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic ld, input logic [3:0] d);
        Valid  = v;
        Load   = ld;
        DataIn = d;
        @(posedge Clk);
        #1;
        Valid  = 1'b0;
        Load   = 1'b0;
    endtask

    task automatic check_a(input string tag, input logic lk, input logic ep,
                           input logic [7:0] ec, input logic [7:0] wc, input logic [3:0] ex);
        check({tag, ".locked"},    {31'd0, locked_a},   {31'd0, lk});
        check({tag, ".errpulse"},  {31'd0, errpulse_a}, {31'd0, ep});
        check({tag, ".errcount"},  {24'd0, errcount_a}, {24'd0, ec});
        check({tag, ".wrapcount"}, {24'd0, wrapcount_a},{24'd0, wc});
        check({tag, ".expected"},  {28'd0, expected_a}, {28'd0, ex});
    endtask

    initial begin
        Rst_n  = 1'b0;
        Valid  = 1'b0;
        Load   = 1'b0;
        Clear  = 1'b0;
        DataIn = 4'd0;
        repeat (2) @(posedge Clk);
        #1;
        check_a("reset", 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
        check("reset.cw2_errcount", {30'd0, errcount_b}, 32'd0);
        Rst_n = 1'b1;

        // 1: first sample relocks without checking
        step(1'b1, 1'b0, 4'd7);
        check_a("t1_first", 1'b1, 1'b0, 8'd0, 8'd0, 4'd8);
        step(1'b1, 1'b0, 4'd8);
        step(1'b1, 1'b0, 4'd9);
        check_a("t1_end", 1'b1, 1'b0, 8'd0, 8'd0, 4'd10);

        // 2: load, then count through the 15->0 wrap
        step(1'b1, 1'b1, 4'd7);
        check_a("t2_load", 1'b1, 1'b0, 8'd0, 8'd0, 4'd8);
        for (int v = 8; v <= 15; v++) step(1'b1, 1'b0, 4'(v));
        check_a("t2_wrap", 1'b1, 1'b0, 8'd0, 8'd1, 4'd0);
        step(1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b0, 4'd1);
        check_a("t2_end", 1'b1, 1'b0, 8'd0, 8'd1, 4'd2);

        // 3: mismatch at Expected=4, hold cycle, relock after two matches
        step(1'b1, 1'b0, 4'd2);
        step(1'b1, 1'b0, 4'd3);
        check_a("t3_at4", 1'b1, 1'b0, 8'd0, 8'd1, 4'd4);
        step(1'b1, 1'b0, 4'd9);
        check_a("t3_err", 1'b0, 1'b1, 8'd1, 8'd1, 4'd10);
        step(1'b0, 1'b0, 4'd5);
        check_a("t3_hold", 1'b0, 1'b0, 8'd1, 8'd1, 4'd10);
        step(1'b1, 1'b0, 4'd10);
        check_a("t3_run1", 1'b0, 1'b0, 8'd1, 8'd1, 4'd11);
        step(1'b1, 1'b0, 4'd11);
        check_a("t3_relock", 1'b1, 1'b0, 8'd1, 8'd1, 4'd12);

        // 4: mismatch inside RESYNC restarts the run
        step(1'b1, 1'b0, 4'd9);
        check_a("t4_err1", 1'b0, 1'b1, 8'd2, 8'd1, 4'd10);
        step(1'b1, 1'b0, 4'd10);
        check_a("t4_run1", 1'b0, 1'b0, 8'd2, 8'd1, 4'd11);
        step(1'b1, 1'b0, 4'd3);
        check_a("t4_err2", 1'b0, 1'b1, 8'd3, 8'd1, 4'd4);
        check("t4.cw2_errcount", {30'd0, errcount_b}, 32'd3);
        step(1'b1, 1'b0, 4'd4);
        check_a("t4_run1b", 1'b0, 1'b0, 8'd3, 8'd1, 4'd5);
        step(1'b1, 1'b0, 4'd5);
        check_a("t4_relock", 1'b1, 1'b0, 8'd3, 8'd1, 4'd6);

        // 5: five back-to-back mismatches; CW=2 instance saturates at 3
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 4'd0);
            check_a($sformatf("t5_err%0d", i), 1'b0, 1'b1, 8'(4 + i), 8'd1, 4'd1);
            check($sformatf("t5_cw2_err%0d", i), {30'd0, errcount_b}, 32'd3);
        end
        Clear = 1'b1;
        step(1'b1, 1'b0, 4'd9);
        Clear = 1'b0;
        check_a("t5_clear", 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
        check("t5_clear.cw2_errcount", {30'd0, errcount_b}, 32'd0);
        check("t5_clear.cw2_errpulse", {31'd0, errpulse_b}, 32'd0);

        // 6: asynchronous reset in the middle of RESYNC
        step(1'b1, 1'b0, 4'd12);
        step(1'b1, 1'b0, 4'd5);
        step(1'b1, 1'b0, 4'd6);
        check_a("t6_resync", 1'b0, 1'b0, 8'd1, 8'd0, 4'd7);
        #2;
        Rst_n = 1'b0;
        #1;
        check_a("t6_async_rst", 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        step(1'b1, 1'b0, 4'd12);
        check_a("t6_relock", 1'b1, 1'b0, 8'd0, 8'd0, 4'd13);

        // wrap counted while in RESYNC, then Load relocks immediately
        step(1'b1, 1'b0, 4'd14);
        check_a("t7_err", 1'b0, 1'b1, 8'd1, 8'd0, 4'd15);
        step(1'b1, 1'b0, 4'd15);
        check_a("t7_wrap", 1'b0, 1'b0, 8'd1, 8'd1, 4'd0);
        step(1'b1, 1'b1, 4'd3);
        check_a("t7_load", 1'b1, 1'b0, 8'd1, 8'd1, 4'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
